// File: rtl/buffer_stream_reader_if.sv
// Valid/ready stream bundle carrying staged buffer entries to the next pipeline stage.
// The master drives valid/data and the slave returns ready.
interface buffer_stream_reader_if #(
    parameter type T = logic [31:0]
);
    logic out_valid;
    T     out_data;
    logic out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/buffer_stream_reader.sv
// Drains a show-ahead circular_buffer read port into a registered valid/ready stream
// through a 2-entry (main + skid) stage. Optional stall counter: READER_PERF_CNT_EN.
module buffer_stream_reader #(
    parameter type T    = logic [31:0],
    parameter int  SKID = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   buf_read_en,
    input  T                       buf_read_data,
    input  logic                   buf_empty,
    input  logic                   flush,
    buffer_stream_reader_if.master stream,
    output logic [1:0]             occupancy
`ifdef READER_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam logic [1:0] CAP = (SKID != 0) ? 2'd2 : 2'd1;

    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic [1:0] push_slot;
    logic       out_valid_q;
    T           entry0;
    T           entry1;
    T           entry0_next;
    T           entry1_next;
    logic       push;
    logic       pop;

    // The pop request looks only at local state and the buffer flag, so out_ready
    // never reaches buf_read_en combinationally; the skid slot absorbs the extra word.
    assign buf_read_en = !buf_empty && !flush && !reset && (cnt < CAP);
    assign push        = buf_read_en;
    assign pop         = out_valid_q && stream.out_ready;
    assign push_slot   = cnt - {1'b0, pop};

    always_comb begin
        cnt_next    = cnt + {1'b0, push} - {1'b0, pop};
        entry0_next = entry0;
        entry1_next = entry1;
        if (pop) begin
            entry0_next = entry1;
        end
        if (push) begin
            if (push_slot == 2'd0) begin
                entry0_next = buf_read_data;
            end else begin
                entry1_next = buf_read_data;
            end
        end
    end

    // Flush drops the staged entries but leaves the data registers alone; only
    // reset zeroes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= 2'd0;
            out_valid_q <= 1'b0;
            entry0      <= '0;
            entry1      <= '0;
        end else if (flush) begin
            cnt         <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            out_valid_q <= (cnt_next != 2'd0);
            entry0      <= entry0_next;
            entry1      <= entry1_next;
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = entry0;
    assign occupancy        = cnt;

`ifdef READER_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (out_valid_q && !stream.out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    cnt_within_cap: assert property (@(posedge clk) disable iff (reset) cnt <= CAP);
    no_pop_when_empty: assert property (@(posedge clk) disable iff (reset) !(buf_read_en && buf_empty));

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Self-checking bench for buffer_stream_reader: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_buffer_stream_reader;

    localparam int CAP = 2;

    typedef struct packed {
        logic        r;
        logic        rdy;
        logic        exp_ren;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_occ;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        buf_read_en;
    logic [31:0] buf_read_data;
    logic        buf_empty;
    logic [1:0]  occupancy;

    logic        s0_reset;
    logic        s0_flush;
    logic        s0_read_en;
    logic [31:0] s0_read_data;
    logic        s0_empty;
    logic [1:0]  s0_occupancy;

`ifdef READER_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] s0_stall_cycles;
    logic [31:0] exp_stall;
`endif

    int checks;
    int failures;

    logic [31:0] buf_q[$];
    logic [31:0] model_q[$];
    logic [31:0] delivered[$];
    logic [31:0] s0_q[$];
    vec_t        vecs[7];

    buffer_stream_reader_if sif ();
    buffer_stream_reader_if sif0 ();

    buffer_stream_reader #(.SKID(1)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .buf_read_en   (buf_read_en),
        .buf_read_data (buf_read_data),
        .buf_empty     (buf_empty),
        .flush         (flush),
        .stream        (sif),
        .occupancy     (occupancy)
`ifdef READER_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    buffer_stream_reader #(.SKID(0)) u_dut_noskid (
        .clk           (clk),
        .reset         (s0_reset),
        .buf_read_en   (s0_read_en),
        .buf_read_data (s0_read_data),
        .buf_empty     (s0_empty),
        .flush         (s0_flush),
        .stream        (sif0),
        .occupancy     (s0_occupancy)
`ifdef READER_PERF_CNT_EN
        ,
        .stall_cycles  (s0_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // One clock of the SKID=1 reader: drive inputs at the falling edge, check the
    // pop request, let the buffer and the reference model advance, check outputs.
    task automatic applyStimulus(input logic r, input logic f, input logic rdy);
        logic        exp_ren;
        logic        dut_ren;
        logic [31:0] head;
        reset         = r;
        flush         = f;
        sif.out_ready = rdy;
        buf_empty     = (buf_q.size() == 0);
        head          = buf_empty ? 32'h0 : buf_q[0];
        buf_read_data = head;
        #1;
        exp_ren = !buf_empty && !f && !r && (model_q.size() < CAP);
        checkOutput("buf_read_en", 32'(buf_read_en), 32'(exp_ren));
        dut_ren = buf_read_en;
        if (!r && !f && sif.out_valid && rdy) delivered.push_back(sif.out_data);
        @(posedge clk);
        #1;
        if (dut_ren && buf_q.size() > 0) void'(buf_q.pop_front());
`ifdef READER_PERF_CNT_EN
        if (r) exp_stall = 32'd0;
        else if (model_q.size() > 0 && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
        if (r || f) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
            if (exp_ren) model_q.push_back(head);
        end
        @(negedge clk);
        checkOutput("out_valid", 32'(sif.out_valid), 32'(model_q.size() > 0));
        checkOutput("occupancy", 32'(occupancy), 32'(model_q.size()));
        if (model_q.size() > 0) checkOutput("out_data", sif.out_data, model_q[0]);
        else if (r) checkOutput("out_data_reset", sif.out_data, 32'h0);
`ifdef READER_PERF_CNT_EN
        checkOutput("stall_cycles", stall_cycles, exp_stall);
`endif
    endtask

    task automatic loadWords(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) buf_q.push_back(base + 32'(i));
    endtask

    initial begin
        logic dut_ren;
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        flush         = 1'b0;
        sif.out_ready = 1'b0;
        s0_reset      = 1'b1;
        s0_flush      = 1'b0;
        sif0.out_ready = 1'b0;
        s0_empty      = 1'b1;
        s0_read_data  = 32'h0;
        buf_empty     = 1'b1;
        buf_read_data = 32'h0;
`ifdef READER_PERF_CNT_EN
        exp_stall     = 32'd0;
`endif

        vecs[0] = '{r: 1'b1, rdy: 1'b1, exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 32'h0,         exp_occ: 2'd0};
        vecs[1] = '{r: 1'b1, rdy: 1'b1, exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 32'h0,         exp_occ: 2'd0};
        vecs[2] = '{r: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_valid: 1'b1, exp_data: 32'hA000_0000, exp_occ: 2'd1};
        vecs[3] = '{r: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_valid: 1'b1, exp_data: 32'hA000_0001, exp_occ: 2'd1};
        vecs[4] = '{r: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_valid: 1'b1, exp_data: 32'hA000_0002, exp_occ: 2'd1};
        vecs[5] = '{r: 1'b0, rdy: 1'b1, exp_ren: 1'b1, exp_valid: 1'b1, exp_data: 32'hA000_0003, exp_occ: 2'd1};
        vecs[6] = '{r: 1'b0, rdy: 1'b1, exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 32'h0,         exp_occ: 2'd0};

        @(negedge clk);
        $display("[TB] vector table: reset hold and streaming A0..A3");
        loadWords(32'hA000_0000, 4);
        for (int i = 0; i < 7; i++) begin
            reset         = vecs[i].r;
            flush         = 1'b0;
            sif.out_ready = vecs[i].rdy;
            buf_empty     = (buf_q.size() == 0);
            buf_read_data = buf_empty ? 32'h0 : buf_q[0];
            #1;
            checkOutput($sformatf("vec%0d_ren", i), 32'(buf_read_en), 32'(vecs[i].exp_ren));
            dut_ren = buf_read_en;
            @(posedge clk);
            #1;
            if (dut_ren && buf_q.size() > 0) void'(buf_q.pop_front());
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid", i), 32'(sif.out_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
            if (vecs[i].exp_valid || vecs[i].r)
                checkOutput($sformatf("vec%0d_data", i), sif.out_data, vecs[i].exp_data);
        end

        $display("[TB] backpressure");
        buf_q.delete();
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadWords(32'hA000_0000, 4);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bp_occupancy", 32'(occupancy), 32'd2);
        checkOutput("bp_read_en", 32'(buf_read_en), 32'd0);
        checkOutput("bp_hold_data", sif.out_data, 32'hA000_0000);
        delivered.delete();
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("bp_count", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < delivered.size() && i < 4; i++)
            checkOutput($sformatf("bp_word%0d", i), delivered[i], 32'hA000_0000 + 32'(i));

        $display("[TB] alternating ready");
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadWords(32'hB000_0000, 8);
        delivered.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, (i % 2) == 0);
        checkOutput("alt_count", 32'(delivered.size()), 32'd8);
        for (int i = 0; i < delivered.size() && i < 8; i++)
            checkOutput($sformatf("alt_word%0d", i), delivered[i], 32'hB000_0000 + 32'(i));

        $display("[TB] flush with two staged entries");
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadWords(32'hA000_0000, 4);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fl_occ_before", 32'(occupancy), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("fl_occ_after", 32'(occupancy), 32'd0);
        checkOutput("fl_valid_after", 32'(sif.out_valid), 32'd0);
        checkOutput("fl_buf_head", (buf_q.size() > 0) ? buf_q[0] : 32'hDEAD_DEAD, 32'hA000_0002);
        delivered.delete();
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fl_count", 32'(delivered.size()), 32'd2);
        for (int i = 0; i < delivered.size() && i < 2; i++)
            checkOutput($sformatf("fl_word%0d", i), delivered[i], 32'hA000_0002 + 32'(i));

`ifdef READER_PERF_CNT_EN
        $display("[TB] stall counter");
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadWords(32'hD000_0000, 4);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("perf_after_stalls", stall_cycles, 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("perf_after_flush", stall_cycles, 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("perf_after_reset", stall_cycles, 32'd0);
`endif

        $display("[TB] randomized traffic");
        buf_q.delete();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (buf_q.size() < 12 && $urandom_range(0, 2) != 0) buf_q.push_back($urandom);
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        $display("[TB] single-entry stage throughput");
        for (int i = 0; i < 6; i++) s0_q.push_back(32'hC000_0000 + 32'(i));
        s0_reset       = 1'b1;
        sif0.out_ready = 1'b1;
        s0_empty       = 1'b0;
        s0_read_data   = s0_q[0];
        repeat (2) @(negedge clk);
        checkOutput("s0_reset_valid", 32'(sif0.out_valid), 32'd0);
        s0_reset = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            logic exp_v;
            s0_empty     = (s0_q.size() == 0);
            s0_read_data = s0_empty ? 32'h0 : s0_q[0];
            #1;
            dut_ren = s0_read_en;
            @(posedge clk);
            #1;
            if (dut_ren && s0_q.size() > 0) void'(s0_q.pop_front());
            @(negedge clk);
            exp_v = ((i % 2) == 1) && (((i - 1) / 2) < 6);
            checkOutput($sformatf("s0_valid%0d", i), 32'(sif0.out_valid), 32'(exp_v));
            checkOutput($sformatf("s0_occ%0d", i), 32'(s0_occupancy), exp_v ? 32'd1 : 32'd0);
            if (exp_v)
                checkOutput($sformatf("s0_data%0d", i), sif0.out_data, 32'hC000_0000 + 32'((i - 1) / 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
